register_file_2r1w: RTL and testbench

- 32-entry by 32-bit integer register file; two read ports, one write port.
- Sits directly upstream of the operand-select muxes. Each read port is built from one mux32 instance, which selects among the 32 register outputs.
- Register x0 is hardwired to zero.
- Writes commit on the rising clock edge. Reads are combinational from current register state.

---
 rtl/register_file_2r1w_if.sv | 35 +++
 rtl/register_file_2r1w.sv | 100 ++++++++++
 tb/tb_register_file_2r1w.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/register_file_2r1w_if.sv
// -----------------------------------------------------------------------------
// register_file_2r1w_if
// Bus bundle for the 2-read / 1-write integer register file.
//   wr_ena   : write enable, sampled on the rising clock edge
//   wr_addr  : destination register index
//   wr_data  : data to write
//   rd_addr0 : read port 0 register index
//   rd_data0 : read port 0 data (combinational)
//   rd_addr1 : read port 1 register index
//   rd_data1 : read port 1 data (combinational)
// master modport: the pipeline stage driving addresses and write data.
// slave modport : the register file itself.
// -----------------------------------------------------------------------------
interface register_file_2r1w_if #(
   parameter int N      = 32,
   parameter int ADDR_W = 5
);
   logic              wr_ena;
   logic [ADDR_W-1:0] wr_addr;
   logic [N-1:0]      wr_data;
   logic [ADDR_W-1:0] rd_addr0;
   logic [N-1:0]      rd_data0;
   logic [ADDR_W-1:0] rd_addr1;
   logic [N-1:0]      rd_data1;

   modport master (
      output wr_ena, wr_addr, wr_data, rd_addr0, rd_addr1,
      input  rd_data0, rd_data1
   );

   modport slave (
      input  wr_ena, wr_addr, wr_data, rd_addr0, rd_addr1,
      output rd_data0, rd_data1
   );
endinterface

// File: rtl/register_file_2r1w.sv
// -----------------------------------------------------------------------------
// register_file_2r1w
// 32 x 32-bit integer register file, two combinational read ports and one
// synchronous write port. Register x0 is a constant zero.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset, clears every register
//   bus   : register_file_2r1w_if.slave (write port + two read ports)
// Build option:
//   REGFILE_WRITE_BYPASS_EN - when defined, a write to a nonzero register is
//   forwarded combinationally to any read port addressing it in the same cycle.
//   When undefined, reads always reflect committed register state.
// -----------------------------------------------------------------------------

// One read port: selects one of the 32 register outputs.
module mux32 #(
   parameter int N = 32
) (
   input  logic [31:0][N-1:0] din,
   input  logic [4:0]         sel,
   output logic [N-1:0]       dout
);
   assign dout = din[sel];
endmodule

module register_file_2r1w #(
   parameter int N      = 32,
   parameter int DEPTH  = 32,
   parameter int ADDR_W = 5
) (
   input  logic                 clk,
   input  logic                 rst_n,
   register_file_2r1w_if.slave  bus
);
   // Flattened view of all register outputs, index = register number.
   logic [DEPTH-1:0][N-1:0] reg_out;
   logic [N-1:0]            mux_out0;
   logic [N-1:0]            mux_out1;

   // x0 is not a flop; writes to it have nowhere to land.
   assign reg_out[0] = '0;

   generate
      for (genvar gi = 1; gi < DEPTH; gi++) begin : g_reg
         logic [N-1:0] data_q;
         logic [N-1:0] data_d;

         always_comb begin
            data_d = data_q;
            if (bus.wr_ena && (bus.wr_addr == ADDR_W'(gi))) begin
               data_d = bus.wr_data;
            end
         end

         // The async clear also makes writes during reset a no-op.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               data_q <= '0;
            end else begin
               data_q <= data_d;
            end
         end

         assign reg_out[gi] = data_q;
      end
   endgenerate

   mux32 #(.N(N)) u_mux_rd0 (
      .din  (reg_out),
      .sel  (bus.rd_addr0),
      .dout (mux_out0)
   );

   mux32 #(.N(N)) u_mux_rd1 (
      .din  (reg_out),
      .sel  (bus.rd_addr1),
      .dout (mux_out1)
   );

`ifdef REGFILE_WRITE_BYPASS_EN
   logic hit0;
   logic hit1;

   // Forward only live, nonzero-destination writes; during reset the
   // registers are already zero, so gating with rst_n keeps outputs at 0.
   always_comb begin
      hit0 = rst_n && bus.wr_ena && (bus.wr_addr != '0) &&
             (bus.wr_addr == bus.rd_addr0);
      hit1 = rst_n && bus.wr_ena && (bus.wr_addr != '0) &&
             (bus.wr_addr == bus.rd_addr1);
   end

   assign bus.rd_data0 = hit0 ? bus.wr_data : mux_out0;
   assign bus.rd_data1 = hit1 ? bus.wr_data : mux_out1;
`else
   assign bus.rd_data0 = mux_out0;
   assign bus.rd_data1 = mux_out1;
`endif

endmodule

// File: tb/tb_register_file_2r1w.sv
// -----------------------------------------------------------------------------
// tb_register_file_2r1w
// Directed and randomized checks of register_file_2r1w against a 32-entry
// shadow array. Inputs change on the falling clock edge; outputs are sampled
// 2 time units later, well away from the rising edge that commits writes.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_register_file_2r1w;
   logic clk;
   logic rst_n;

   register_file_2r1w_if #(.N(32), .ADDR_W(5)) bus ();

   register_file_2r1w #(.N(32), .DEPTH(32), .ADDR_W(5)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          checks;
   int          errors;
   logic [31:0] model [32];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end else begin
         $display("ok   %s value=%h", tag, obs);
      end
   endtask

   // Expected read value from the architectural rules, given the current
   // inputs and the shadow register contents.
   function automatic logic [31:0] exp_rd(input logic [4:0] a);
      if (!rst_n || a == 5'd0) return 32'h0;
`ifdef REGFILE_WRITE_BYPASS_EN
      if (bus.wr_ena && bus.wr_addr == a) return bus.wr_data;
`endif
      return model[a];
   endfunction

   function automatic void clear_model();
      for (int i = 0; i < 32; i++) model[i] = 32'h0;
   endfunction

   // Let one rising edge commit the current inputs, then return at the next
   // falling edge ready for new stimulus.
   task automatic tick();
      @(posedge clk);
      if (rst_n && bus.wr_ena && bus.wr_addr != 5'd0) model[bus.wr_addr] = bus.wr_data;
      if (!rst_n) clear_model();
      @(negedge clk);
   endtask

   task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                        input logic [4:0] ra0, input logic [4:0] ra1);
      bus.wr_ena   = we;
      bus.wr_addr  = wa;
      bus.wr_data  = wd;
      bus.rd_addr0 = ra0;
      bus.rd_addr1 = ra1;
   endtask

   initial begin
      int          err_before;
      logic [31:0] v;
      checks = 0;
      errors = 0;
      clear_model();
      rst_n = 1'b0;
      drive(1'b1, 5'd3, 32'hCAFE_F00D, 5'd3, 5'd5);

      // Reset: write attempt held across an edge must be ignored.
      #2;
      check("reset_rd0", bus.rd_data0, 32'h0);
      check("reset_rd1", bus.rd_data1, 32'h0);
      tick();
      check("reset_write_ignored", bus.rd_data0, 32'h0);
      rst_n = 1'b1;

      // Write x5, then assert reset mid-cycle with no clock edge.
      drive(1'b1, 5'd5, 32'hDEAD_BEEF, 5'd5, 5'd5);
      tick();
      drive(1'b0, 5'd0, 32'h0, 5'd5, 5'd5);
      #2;
      check("x5_written", bus.rd_data0, 32'hDEAD_BEEF);
      rst_n = 1'b0;
      #1;
      check("async_reset_rd0", bus.rd_data0, 32'h0);
      check("async_reset_rd1", bus.rd_data1, 32'h0);
      // Reset wins over a simultaneous write.
      drive(1'b1, 5'd5, 32'h1234_5678, 5'd5, 5'd5);
      tick();
      #2;
      check("reset_beats_write", bus.rd_data0, 32'h0);
      rst_n = 1'b1;

      // Fill x1..x31 then sweep both ports in opposite directions.
      for (int i = 1; i < 32; i++) begin
         drive(1'b1, 5'(i), 32'h1000_0000 + 32'(i), 5'd0, 5'd0);
         tick();
      end
      for (int a = 0; a < 32; a++) begin
         drive(1'b0, 5'd0, 32'h0, 5'(a), 5'(31 - a));
         #2;
         check($sformatf("sweep_rd0_a%0d", a), bus.rd_data0,
               (a == 0) ? 32'h0 : 32'h1000_0000 + 32'(a));
         check($sformatf("sweep_rd1_a%0d", 31 - a), bus.rd_data1,
               (a == 31) ? 32'h0 : 32'h1000_0000 + 32'(31 - a));
         @(negedge clk);
      end

      // x0 protection.
      drive(1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0);
      #2;
      check("x0_same_cycle", bus.rd_data0, 32'h0);
      tick();
      drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
      #2;
      check("x0_rd0", bus.rd_data0, 32'h0);
      check("x0_rd1", bus.rd_data1, 32'h0);

      // Write enable gating.
      drive(1'b1, 5'd7, 32'h1234_5678, 5'd7, 5'd7);
      tick();
      drive(1'b0, 5'd7, 32'hAAAA_AAAA, 5'd7, 5'd7);
      tick();
      #2;
      check("wr_ena_gating_rd0", bus.rd_data0, 32'h1234_5678);
      check("wr_ena_gating_rd1", bus.rd_data1, 32'h1234_5678);

      // Same-cycle read and write of one register.
      drive(1'b1, 5'd9, 32'h11, 5'd9, 5'd9);
      tick();
      drive(1'b1, 5'd9, 32'h22, 5'd9, 5'd9);
      #2;
`ifdef REGFILE_WRITE_BYPASS_EN
      check("same_cycle_bypass", bus.rd_data0, 32'h22);
`else
      check("same_cycle_old", bus.rd_data0, 32'h11);
`endif
      tick();
      drive(1'b0, 5'd0, 32'h0, 5'd9, 5'd9);
      #2;
      check("after_edge_new", bus.rd_data0, 32'h22);
      check("both_ports_equal", bus.rd_data1, 32'h22);

      // Randomized traffic against the shadow model.
      for (int it = 0; it < 1000; it++) begin
         v = $urandom;
         drive(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), v,
               5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
         #2;
         err_before = errors;
         check($sformatf("rand%0d_rd0_a%0d", it, bus.rd_addr0), bus.rd_data0, exp_rd(bus.rd_addr0));
         check($sformatf("rand%0d_rd1_a%0d", it, bus.rd_addr1), bus.rd_data1, exp_rd(bus.rd_addr1));
         if (errors != err_before) begin
            $display("CHECKS %0d ERRORS %0d", checks, errors);
            $fatal(1, "random phase stopped at iteration %0d", it);
         end
         tick();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
